axi_lite_to_axi_stream: RTL and testbench

//  AXI4-Lite slave that turns CPU register writes into AXI-Stream beats on a master port (Zynq-to-FPGA direction).
//  It is the inverse of the stream-to-AXI bridge and sits between the PS GP port and the FPGA packet datapath.

---
 rtl/axi_stream_pkg.sv | 25 ++
 rtl/axis_skid_buffer.sv | 53 +++++
 rtl/axi_lite_to_axi_stream.sv | 192 +++++++++++++++++++
 tb/tb_axi_lite_to_axi_stream.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_stream_pkg.sv
// rtl/axi_stream_pkg.sv - shared types and register offsets for the AXI-Lite/AXI-Stream bridges
package axi_stream_pkg;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_SLVERR = 2'b10
   } resp_e;

   // Word offsets, decoded from address bits [3:2]
   localparam logic [1:0] REG_DATA      = 2'd0;
   localparam logic [1:0] REG_DATA_LAST = 2'd1;
   localparam logic [1:0] REG_STATUS    = 2'd2;
   localparam logic [1:0] REG_CTRL      = 2'd3;

   // Beats are sized for the widest supported bus; narrower bridges leave the top bits zero
   localparam int MAX_DATA_WIDTH = 64;
   localparam int MAX_KEEP_WIDTH = MAX_DATA_WIDTH / 8;

   typedef struct packed {
      logic [MAX_DATA_WIDTH-1:0] tdata;
      logic [MAX_KEEP_WIDTH-1:0] tkeep;
      logic                      tlast;
   } beat_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// rtl/axis_skid_buffer.sv - 2-entry register FIFO (out + temp) driving an AXI-Stream master
module axis_skid_buffer
   import axi_stream_pkg::*;
(
   input  logic       axi_aclk,
   input  logic       axi_aresetn,
   input  logic       push,
   input  beat_t      push_data,
   output beat_t      m_axis_beat,
   output logic       m_axis_tvalid,
   input  logic       m_axis_tready,
   output logic [1:0] occupancy
);

   beat_t out_beat;
   beat_t tmp_beat;
   logic  out_valid;
   logic  tmp_valid;
   logic  pop;

   assign pop           = out_valid && m_axis_tready;
   assign m_axis_beat   = out_beat;
   assign m_axis_tvalid = out_valid;
   assign occupancy     = {1'b0, out_valid} + {1'b0, tmp_valid};

   // Temp only fills when out is occupied and not draining; a push while full is ignored
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         out_valid <= 1'b0;
         tmp_valid <= 1'b0;
         out_beat  <= '0;
         tmp_beat  <= '0;
      end else if (tmp_valid) begin
         if (pop) begin
            out_beat  <= tmp_beat;
            tmp_valid <= 1'b0;
         end
      end else if (out_valid) begin
         if (push && pop) begin
            out_beat <= push_data;
         end else if (push) begin
            tmp_beat  <= push_data;
            tmp_valid <= 1'b1;
         end else if (pop) begin
            out_valid <= 1'b0;
         end
      end else if (push) begin
         out_beat  <= push_data;
         out_valid <= 1'b1;
      end
   end

endmodule

// File: rtl/axi_lite_to_axi_stream.sv
// rtl/axi_lite_to_axi_stream.sv - AXI4-Lite register writes turned into AXI-Stream beats
module axi_lite_to_axi_stream
   import axi_stream_pkg::*;
#(
   parameter int AXI_DATA_WIDTH  = 32,
   parameter int AXI_ADDR_WIDTH  = 32,
   parameter int AXIS_KEEP_WIDTH = AXI_DATA_WIDTH / 8,
   parameter int FRAME_CNT_WIDTH = 16
) (
   input  logic                       axi_aclk,
   input  logic                       axi_aresetn,
   input  logic [AXI_ADDR_WIDTH-1:0]  s_axi_awaddr,
   input  logic                       s_axi_awvalid,
   output logic                       s_axi_awready,
   input  logic [AXI_DATA_WIDTH-1:0]  s_axi_wdata,
   input  logic [AXIS_KEEP_WIDTH-1:0] s_axi_wstrb,
   input  logic                       s_axi_wvalid,
   output logic                       s_axi_wready,
   output logic [1:0]                 s_axi_bresp,
   output logic                       s_axi_bvalid,
   input  logic                       s_axi_bready,
   input  logic [AXI_ADDR_WIDTH-1:0]  s_axi_araddr,
   input  logic                       s_axi_arvalid,
   output logic                       s_axi_arready,
   output logic [AXI_DATA_WIDTH-1:0]  s_axi_rdata,
   output logic [1:0]                 s_axi_rresp,
   output logic                       s_axi_rvalid,
   input  logic                       s_axi_rready,
   output logic [AXI_DATA_WIDTH-1:0]  m_axis_tdata,
   output logic [AXIS_KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                       m_axis_tlast,
   output logic                       m_axis_tvalid,
   input  logic                       m_axis_tready
);

   logic                       alive;
   logic                       aw_held;
   logic [1:0]                 aw_reg;
   logic                       w_held;
   logic [AXI_DATA_WIDTH-1:0]  w_data;
   logic [AXIS_KEEP_WIDTH-1:0] w_strb;
   logic [1:0]                 occupancy;
   logic                       is_data;
   logic                       strb_zero;
   logic                       commit;
   logic                       push;
   logic                       clear_cnt;
   logic                       pop_last;
   resp_e                      wr_resp;
   beat_t                      push_beat;
   beat_t                      out_beat;
   logic [FRAME_CNT_WIDTH-1:0] frame_cnt;
   logic                       frame_open;
   logic [31:0]                status_word;
   logic [AXI_DATA_WIDTH-1:0]  status_data;
   logic                       unused_bits;

   // Readies stay low during reset and on the first edge out of it
   assign s_axi_awready = alive && !aw_held && !s_axi_bvalid;
   assign s_axi_wready  = alive && !w_held && !s_axi_bvalid;
   assign s_axi_arready = alive && !s_axi_rvalid;

   assign is_data   = (aw_reg == REG_DATA) || (aw_reg == REG_DATA_LAST);
   assign strb_zero = (w_strb == '0);
   assign commit    = aw_held && w_held && !s_axi_bvalid && (!is_data || occupancy != 2'd2);
   assign push      = commit && is_data && !strb_zero;
   assign clear_cnt = commit && (aw_reg == REG_CTRL) && w_data[0];
   assign pop_last  = m_axis_tvalid && m_axis_tready && m_axis_tlast;

   assign m_axis_tdata = out_beat.tdata[AXI_DATA_WIDTH-1:0];
   assign m_axis_tkeep = out_beat.tkeep[AXIS_KEEP_WIDTH-1:0];
   assign m_axis_tlast = out_beat.tlast;
   assign unused_bits  = ^{s_axi_awaddr, s_axi_araddr, out_beat};

   // Empty strobes on a data register and any STATUS write are rejected
   always_comb begin
      wr_resp = RESP_OKAY;
      if ((is_data && strb_zero) || aw_reg == REG_STATUS) begin
         wr_resp = RESP_SLVERR;
      end
   end

   // Widen the committed write into a package beat
   always_comb begin
      push_beat                            = '0;
      push_beat.tdata[AXI_DATA_WIDTH-1:0]  = w_data;
      push_beat.tkeep[AXIS_KEEP_WIDTH-1:0] = w_strb;
      push_beat.tlast                      = (aw_reg == REG_DATA_LAST);
   end

   // Live STATUS word, zero-extended to the bus width
   always_comb begin
      status_word                        = '0;
      status_word[0]                     = frame_open;
      status_word[2:1]                   = occupancy;
      status_word[16 +: FRAME_CNT_WIDTH] = frame_cnt;
      status_data                        = '0;
      status_data[31:0]                  = status_word;
   end

   // Marks the bridge as out of reset so readies can rise
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) alive <= 1'b0;
      else              alive <= 1'b1;
   end

   // Write-address hold: filled on handshake, emptied on commit
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         aw_held <= 1'b0;
         aw_reg  <= 2'd0;
      end else if (s_axi_awvalid && s_axi_awready) begin
         aw_held <= 1'b1;
         aw_reg  <= s_axi_awaddr[3:2];
      end else if (commit) begin
         aw_held <= 1'b0;
      end
   end

   // Write-data hold: filled on handshake, emptied on commit
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         w_held <= 1'b0;
         w_data <= '0;
         w_strb <= '0;
      end else if (s_axi_wvalid && s_axi_wready) begin
         w_held <= 1'b1;
         w_data <= s_axi_wdata;
         w_strb <= s_axi_wstrb;
      end else if (commit) begin
         w_held <= 1'b0;
      end
   end

   // Write response raised at commit, held until the master takes it
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         s_axi_bvalid <= 1'b0;
         s_axi_bresp  <= RESP_OKAY;
      end else if (commit) begin
         s_axi_bvalid <= 1'b1;
         s_axi_bresp  <= wr_resp;
      end else if (s_axi_bready) begin
         s_axi_bvalid <= 1'b0;
      end
   end

   // Read response captured at the AR handshake; only STATUS is readable
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         s_axi_rvalid <= 1'b0;
         s_axi_rdata  <= '0;
         s_axi_rresp  <= RESP_OKAY;
      end else if (s_axi_arvalid && s_axi_arready) begin
         s_axi_rvalid <= 1'b1;
         if (s_axi_araddr[3:2] == REG_STATUS) begin
            s_axi_rdata <= status_data;
            s_axi_rresp <= RESP_OKAY;
         end else begin
            s_axi_rdata <= '0;
            s_axi_rresp <= RESP_SLVERR;
         end
      end else if (s_axi_rready) begin
         s_axi_rvalid <= 1'b0;
      end
   end

   // Tracks whether the most recently pushed beat left a frame open
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn)  frame_open <= 1'b0;
      else if (push)     frame_open <= !push_beat.tlast;
   end

   // Completed-frame counter; a software clear beats a same-edge increment
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn)   frame_cnt <= '0;
      else if (clear_cnt) frame_cnt <= '0;
      else if (pop_last)  frame_cnt <= frame_cnt + 1'b1;
   end

   axis_skid_buffer u_skid (
      .axi_aclk      (axi_aclk),
      .axi_aresetn   (axi_aresetn),
      .push          (push),
      .push_data     (push_beat),
      .m_axis_beat   (out_beat),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .occupancy     (occupancy)
   );

endmodule

// File: tb/tb_axi_lite_to_axi_stream.sv
// tb/tb_axi_lite_to_axi_stream.sv - directed bench with a queue model of the stream and STATUS
module tb_axi_lite_to_axi_stream;

   localparam int DW  = 32;
   localparam int AW  = 32;
   localparam int KW  = 4;
   localparam int FCW = 4;

   logic          clk = 1'b0;
   logic          resetn;
   logic [AW-1:0] awaddr;
   logic          awvalid;
   logic          awready;
   logic [DW-1:0] wdata;
   logic [KW-1:0] wstrb;
   logic          wvalid;
   logic          wready;
   logic [1:0]    bresp;
   logic          bvalid;
   logic          bready;
   logic [AW-1:0] araddr;
   logic          arvalid;
   logic          arready;
   logic [DW-1:0] rdata;
   logic [1:0]    rresp;
   logic          rvalid;
   logic          rready;
   logic [DW-1:0] tdata;
   logic [KW-1:0] tkeep;
   logic          tlast;
   logic          tvalid;
   logic          tready;

   int vectors = 0;
   int errors  = 0;

   logic [36:0]    exp_q[$];
   logic [36:0]    mon_beat;
   logic [FCW-1:0] model_cnt  = '0;
   logic           model_open = 1'b0;

   always #5 clk = ~clk;

   axi_lite_to_axi_stream #(
      .AXI_DATA_WIDTH  (DW),
      .AXI_ADDR_WIDTH  (AW),
      .AXIS_KEEP_WIDTH (KW),
      .FRAME_CNT_WIDTH (FCW)
   ) dut (
      .axi_aclk      (clk),
      .axi_aresetn   (resetn),
      .s_axi_awaddr  (awaddr),
      .s_axi_awvalid (awvalid),
      .s_axi_awready (awready),
      .s_axi_wdata   (wdata),
      .s_axi_wstrb   (wstrb),
      .s_axi_wvalid  (wvalid),
      .s_axi_wready  (wready),
      .s_axi_bresp   (bresp),
      .s_axi_bvalid  (bvalid),
      .s_axi_bready  (bready),
      .s_axi_araddr  (araddr),
      .s_axi_arvalid (arvalid),
      .s_axi_arready (arready),
      .s_axi_rdata   (rdata),
      .s_axi_rresp   (rresp),
      .s_axi_rvalid  (rvalid),
      .s_axi_rready  (rready),
      .m_axis_tdata  (tdata),
      .m_axis_tkeep  (tkeep),
      .m_axis_tlast  (tlast),
      .m_axis_tvalid (tvalid),
      .m_axis_tready (tready)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [31:0] model_status();
      int occ;
      occ = (exp_q.size() > 2) ? 2 : exp_q.size();
      return {12'h0, model_cnt, 13'h0, occ[1:0], model_open};
   endfunction

   // Every cycle the stream is valid, its beat must be the oldest outstanding write
   always @(negedge clk) begin
      if (resetn && tvalid) begin
         vectors++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL beat_unexpected actual=%0h required=none", {tdata, tkeep, tlast});
         end else begin
            if ({tdata, tkeep, tlast} !== exp_q[0]) begin
               errors++;
               $display("FAIL beat actual=%0h required=%0h", {tdata, tkeep, tlast}, exp_q[0]);
            end
            if (tready) begin
               mon_beat = exp_q.pop_front();
               if (mon_beat[0]) model_cnt = model_cnt + 1'b1;
            end
         end
      end
   end

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int w_lead, output logic [1:0] resp, output int lat, output logic tv);
      bit aw_done, w_done, aw_hs, w_hs;
      int t;
      aw_done = 0; w_done = 0; lat = 0; tv = 0;
      @(posedge clk); #1;
      awaddr = addr; wdata = data; wstrb = strb; wvalid = 1'b1;
      if (w_lead == 0) awvalid = 1'b1;
      t = 0;
      while (!(aw_done && w_done) && t < 200) begin
         @(negedge clk);
         aw_hs = awvalid && awready;
         w_hs  = wvalid && wready;
         @(posedge clk); #1;
         t++;
         if (aw_hs) begin aw_done = 1; awvalid = 1'b0; end
         if (w_hs)  begin w_done  = 1; wvalid  = 1'b0; end
         if (!aw_done && !awvalid && t >= w_lead) awvalid = 1'b1;
      end
      check("aw_w_handshake", {aw_done, w_done}, 2'b11);
      if ((addr[3:2] == 2'd0 || addr[3:2] == 2'd1) && strb != 4'h0) begin
         exp_q.push_back({data, strb, addr[3:2] == 2'd1});
         model_open = (addr[3:2] == 2'd0);
      end
      bready = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!bvalid && t < 200);
      check("b_arrives", bvalid, 1'b1);
      lat = t; tv = tvalid; resp = bresp;
      @(posedge clk); #1;
      bready = 1'b0;
      if (addr[3:2] == 2'd3 && data[0]) model_cnt = '0;
   endtask

   task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
      int t;
      @(posedge clk); #1;
      araddr = addr; arvalid = 1'b1; t = 0;
      do begin @(negedge clk); t++; end while (!arready && t < 200);
      check("ar_handshake", arready, 1'b1);
      @(posedge clk); #1;
      arvalid = 1'b0; rready = 1'b1; t = 0;
      do begin @(negedge clk); t++; end while (!rvalid && t < 200);
      check("r_arrives", rvalid, 1'b1);
      data = rdata; resp = rresp;
      @(posedge clk); #1;
      rready = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0]  r, r3;
      logic [31:0] rd;
      int          lat, t;
      logic        tv;

      resetn = 1'b0; awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
      bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0; tready = 1'b1;

      // Reset state
      #12;
      check("rst_readies", {awready, wready, arready}, 3'b000);
      check("rst_valids", {bvalid, rvalid, tvalid}, 3'b000);
      check("rst_data", {bresp, rresp, rdata, tdata, tkeep, tlast}, '0);
      @(negedge clk); resetn = 1'b1;

      // 1: two beats, second closes the frame
      axi_write(32'h0, 32'hA5A5A5A5, 4'hF, 0, r, lat, tv);
      check("t1_bresp_data", r, 2'b00);
      check("t1_latency", lat, 2);
      check("t1_tvalid_with_b", tv, 1'b1);
      axi_write(32'h4, 32'h5A5A5A5A, 4'hF, 0, r, lat, tv);
      check("t1_bresp_last", r, 2'b00);
      axi_read(32'h8, rd, r);
      check("t1_status", rd, 32'h0001_0000);
      check("t1_status_model", model_status(), 32'h0001_0000);
      check("t1_rresp", r, 2'b00);

      // 2: W leads AW by three cycles
      axi_write(32'h4, 32'h11, 4'hF, 3, r, lat, tv);
      check("t2_bresp", r, 2'b00);
      check("t2_latency", lat, 2);
      check("t2_tvalid_with_b", tv, 1'b1);

      // 3: stalled stream fills the buffer, third write is held off
      tready = 1'b0;
      axi_write(32'h0, 32'h100, 4'hF, 0, r, lat, tv);
      check("t3_bresp1", r, 2'b00);
      axi_write(32'h0, 32'h101, 4'h3, 0, r, lat, tv);
      check("t3_bresp2", r, 2'b00);
      fork
         axi_write(32'h0, 32'h102, 4'hC, 0, r3, lat, tv);
         begin
            repeat (8) @(posedge clk);
            @(negedge clk);
            check("t3_b_withheld", bvalid, 1'b0);
            axi_read(32'h8, rd, r);
            check("t3_occupancy", rd[2:1], 2'd2);
            check("t3_status", rd, model_status());
            @(posedge clk); #1;
            tready = 1'b1;
         end
      join
      check("t3_bresp3", r3, 2'b00);
      repeat (6) @(posedge clk);
      axi_read(32'h8, rd, r);
      check("t3_status_drained", rd, model_status());

      // 4: error responses
      axi_write(32'h0, 32'hDEAD, 4'h0, 0, r, lat, tv);
      check("t4_zero_strb", r, 2'b10);
      axi_write(32'h8, 32'hFFFF, 4'hF, 0, r, lat, tv);
      check("t4_status_write", r, 2'b10);
      axi_read(32'hC, rd, r);
      check("t4_ctrl_rdata", rd, 32'h0);
      check("t4_ctrl_rresp", r, 2'b10);
      axi_read(32'h8, rd, r);
      check("t4_status_unchanged", rd, model_status());

      // 5: counter wrap and clear-versus-increment
      axi_write(32'hC, 32'h1, 4'hF, 0, r, lat, tv);
      check("t5_clear_bresp", r, 2'b00);
      for (int i = 0; i < 15; i++) axi_write(32'h4, 32'h200 + i, 4'hF, 0, r, lat, tv);
      axi_read(32'h8, rd, r);
      check("t5_cnt_max", rd, 32'h000F_0000);
      check("t5_cnt_max_model", rd, model_status());
      axi_write(32'h4, 32'h300, 4'hF, 0, r, lat, tv);
      axi_read(32'h8, rd, r);
      check("t5_cnt_wrap", rd, 32'h0);
      tready = 1'b0;
      axi_write(32'h4, 32'h77, 4'hF, 0, r, lat, tv);
      @(posedge clk); #1;
      awaddr = 32'hC; awvalid = 1'b1; wdata = 32'h1; wstrb = 4'hF; wvalid = 1'b1; t = 0;
      do begin @(negedge clk); t++; end while (!(awready && wready) && t < 200);
      check("t5_ctrl_hs", {awready, wready}, 2'b11);
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0; tready = 1'b1; bready = 1'b1; t = 0;
      do begin @(negedge clk); t++; end while (!bvalid && t < 200);
      check("t5_ctrl_b", bvalid, 1'b1);
      check("t5_ctrl_bresp", bresp, 2'b00);
      @(posedge clk); #1;
      bready = 1'b0; model_cnt = '0;
      axi_read(32'h8, rd, r);
      check("t5_clear_wins", rd, 32'h0);
      check("t5_clear_model", rd, model_status());

      // 6: reset with two beats buffered and B/R responses pending
      tready = 1'b0;
      axi_write(32'h0, 32'hAAAA0001, 4'hF, 0, r, lat, tv);
      axi_write(32'h0, 32'hAAAA0002, 4'hF, 0, r, lat, tv);
      @(posedge clk); #1;
      awaddr = 32'hC; awvalid = 1'b1; wdata = 32'h0; wstrb = 4'hF; wvalid = 1'b1; t = 0;
      do begin @(negedge clk); t++; end while (!(awready && wready) && t < 200);
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0; t = 0;
      do begin @(negedge clk); t++; end while (!bvalid && t < 200);
      @(posedge clk); #1;
      araddr = 32'h8; arvalid = 1'b1; t = 0;
      do begin @(negedge clk); t++; end while (!arready && t < 200);
      @(posedge clk); #1;
      arvalid = 1'b0; t = 0;
      do begin @(negedge clk); t++; end while (!rvalid && t < 200);
      check("t6_pre_valids", {tvalid, bvalid, rvalid}, 3'b111);
      check("t6_pre_status", rdata, model_status());
      #2;
      resetn = 1'b0;
      exp_q.delete(); model_cnt = '0; model_open = 1'b0;
      #1;
      check("t6_async_valids", {tvalid, bvalid, rvalid}, 3'b000);
      check("t6_async_readies", {awready, wready, arready}, 3'b000);
      @(posedge clk); #1;
      resetn = 1'b1; tready = 1'b1;
      axi_read(32'h8, rd, r);
      check("t6_status_after", rd, 32'h0);

      repeat (4) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
